// File: rtl/mmio_pkg.sv
// Shared definitions for the board I/O block: register map, status/enable bit
// positions and the register-select type produced by the address decoder.
package mmio_pkg;

    localparam int OFF_W = 9;

    localparam logic [OFF_W-1:0] OFF_HEX   = 9'h000;
    localparam logic [OFF_W-1:0] OFF_LEDR  = 9'h004;
    localparam logic [OFF_W-1:0] OFF_LEDG  = 9'h008;
    localparam logic [OFF_W-1:0] OFF_KDATA = 9'h010;
    localparam logic [OFF_W-1:0] OFF_SDATA = 9'h014;
    localparam logic [OFF_W-1:0] OFF_TCNT  = 9'h020;
    localparam logic [OFF_W-1:0] OFF_TLIM  = 9'h024;
    localparam logic [OFF_W-1:0] OFF_KCTRL = 9'h110;
    localparam logic [OFF_W-1:0] OFF_SCTRL = 9'h114;
    localparam logic [OFF_W-1:0] OFF_TCTRL = 9'h120;
    localparam logic [OFF_W-1:0] OFF_IRQEN = 9'h130;

    localparam int IRQ_W   = 3;
    localparam int IRQ_KEY = 0;
    localparam int IRQ_SW  = 1;
    localparam int IRQ_TMR = 2;

    localparam int SCTRL_RDY = 0;
    localparam int SCTRL_OVR = 1;
    localparam int TCTRL_RDY = 0;
    localparam int TCTRL_OVR = 2;

    localparam int TLIM_RST = 1000;

    typedef enum logic [3:0] {
        REG_NONE, REG_HEX, REG_LEDR, REG_LEDG, REG_KDATA, REG_SDATA,
        REG_KCTRL, REG_SCTRL, REG_TCNT, REG_TLIM, REG_TCTRL, REG_IRQEN
    } reg_e;

    function automatic reg_e decode_off(input logic [OFF_W-1:0] off);
        case (off)
            OFF_HEX:   return REG_HEX;
            OFF_LEDR:  return REG_LEDR;
            OFF_LEDG:  return REG_LEDG;
            OFF_KDATA: return REG_KDATA;
            OFF_SDATA: return REG_SDATA;
            OFF_KCTRL: return REG_KCTRL;
            OFF_SCTRL: return REG_SCTRL;
            OFF_TCNT:  return REG_TCNT;
            OFF_TLIM:  return REG_TLIM;
            OFF_TCTRL: return REG_TCTRL;
            OFF_IRQEN: return REG_IRQEN;
            default:   return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mmio_if.sv
// CPU-side load/store port of the I/O block; the CPU is master, the block is slave.
interface mmio_if #(parameter int DBITS = 32);
    logic [DBITS-1:0] addr;
    logic             wr_en;
    logic [DBITS-1:0] wr_data;
    logic [DBITS-1:0] rd_data;
    logic             rd_hit;

    modport master (output addr, wr_en, wr_data, input  rd_data, rd_hit);
    modport slave  (input  addr, wr_en, wr_data, output rd_data, rd_hit);
endinterface

// File: rtl/mmio_controller_debouncer.sv
// Two-flop synchroniser followed by a per-bit stability counter; o_chg flags the
// cycle in which a bit of o_q is about to flip.
module io_debouncer #(
    parameter int WIDTH  = 1,
    parameter int CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_chg
);
    localparam int            CW   = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [WIDTH-1:0] r_sync1, r_sync2, r_q;
    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] w_flip;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_flip = '0;
        for (int i = 0; i < WIDTH; i++)
            w_flip[i] = (r_sync2[i] != r_q[i]) && (r_cnt[i] == LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_q     <= '0;
            // NOTE: the counter array is small flop state, not RAM, so it is reset like any register.
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_q[i] || w_flip[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
                if (w_flip[i]) r_q[i] <= r_sync2[i];
            end
        end
    end

    assign o_q   = r_q;
    assign o_chg = w_flip;
endmodule

// File: rtl/mmio_controller.sv
// Board I/O register block beside data memory: LED/HEX outputs, debounced KEY/SW
// with sticky event capture, a prescaled interval timer and one maskable irq.
module mmio_controller
    import mmio_pkg::*;
#(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDR_BASE       = 32'hF000_0000,
    parameter int               NKEY            = 4,
    parameter int               NSW             = 10,
    parameter int               NLEDR           = 10,
    parameter int               NLEDG           = 8,
    parameter int               NHEX            = 4,
    parameter int               DEBOUNCE_CYCLES = 100000,
    parameter int               TIMER_PRESCALE  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    mmio_if.slave             bus,
    input  logic [NKEY-1:0]   key_in,
    input  logic [NSW-1:0]    sw_in,
    output logic [NLEDR-1:0]  ledr,
    output logic [NLEDG-1:0]  ledg,
    output logic [4*NHEX-1:0] hex,
    output logic              irq
);
    localparam int HEXW = 4 * NHEX;
    localparam int PW   = $clog2(TIMER_PRESCALE + 1);

    logic [HEXW-1:0]  r_hex;
    logic [NLEDR-1:0] r_ledr;
    logic [NLEDG-1:0] r_ledg;
    logic [NKEY-1:0]  r_key_rdy, r_key_ovr;
    logic             r_sw_rdy, r_sw_ovr, r_t_rdy, r_t_ovr, r_irq;
    logic [DBITS-1:0] r_tcnt, r_tlim;
    logic [PW-1:0]    r_psc;
    logic [IRQ_W-1:0] r_irqen;

    logic [NKEY-1:0]  w_key_n, w_key_q, w_key_chg, w_key_press, w_kclr_rdy, w_kclr_ovr;
    logic [NSW-1:0]   w_sw_q, w_sw_chg;
    logic             w_sw_evt, w_tick, w_wrap, w_tmr_wr;
    logic [DBITS-1:0] w_tlim_eff, w_rd_data;
    logic [IRQ_W-1:0] w_irq_src;
    reg_e             w_sel;
    logic             w_we_hex, w_we_ledr, w_we_ledg, w_we_tcnt, w_we_tlim;
    logic             w_we_kctrl, w_we_sctrl, w_we_tctrl, w_we_irqen;

    // KEY pins are active-low; inverting first makes 1 = pressed everywhere downstream.
    assign w_key_n = ~key_in;

    io_debouncer #(.WIDTH(NKEY), .CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clk(clk), .reset(reset), .i_raw(w_key_n), .o_q(w_key_q), .o_chg(w_key_chg)
    );
    io_debouncer #(.WIDTH(NSW), .CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
        .clk(clk), .reset(reset), .i_raw(sw_in), .o_q(w_sw_q), .o_chg(w_sw_chg)
    );

    assign w_key_press = w_key_chg & ~w_key_q;
    assign w_sw_evt    = |w_sw_chg;

    assign w_sel = (bus.addr[DBITS-1:OFF_W] == ADDR_BASE[DBITS-1:OFF_W])
                 ? decode_off(bus.addr[OFF_W-1:0]) : REG_NONE;

    assign w_we_hex   = bus.wr_en && (w_sel == REG_HEX);
    assign w_we_ledr  = bus.wr_en && (w_sel == REG_LEDR);
    assign w_we_ledg  = bus.wr_en && (w_sel == REG_LEDG);
    assign w_we_tcnt  = bus.wr_en && (w_sel == REG_TCNT);
    assign w_we_tlim  = bus.wr_en && (w_sel == REG_TLIM);
    assign w_we_kctrl = bus.wr_en && (w_sel == REG_KCTRL);
    assign w_we_sctrl = bus.wr_en && (w_sel == REG_SCTRL);
    assign w_we_tctrl = bus.wr_en && (w_sel == REG_TCTRL);
    assign w_we_irqen = bus.wr_en && (w_sel == REG_IRQEN);

    assign w_kclr_rdy = w_we_kctrl ? bus.wr_data[NKEY-1:0]      : '0;
    assign w_kclr_ovr = w_we_kctrl ? bus.wr_data[2*NKEY-1:NKEY] : '0;

    // A TCNT/TLIM store restarts the prescaler and cancels any tick due that cycle.
    assign w_tmr_wr   = w_we_tcnt || w_we_tlim;
    assign w_tlim_eff = (r_tlim == '0) ? DBITS'(1) : r_tlim;
    assign w_tick     = (r_psc == PW'(TIMER_PRESCALE - 1)) && !w_tmr_wr;
    assign w_wrap     = w_tick && (r_tcnt == w_tlim_eff - DBITS'(1));

    assign w_irq_src[IRQ_KEY] = |r_key_rdy;
    assign w_irq_src[IRQ_SW]  = r_sw_rdy;
    assign w_irq_src[IRQ_TMR] = r_t_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hex     <= '0;
            r_ledr    <= '0;
            r_ledg    <= '0;
            r_tcnt    <= '0;
            r_tlim    <= DBITS'(TLIM_RST);
            r_psc     <= '0;
            r_key_rdy <= '0;
            r_key_ovr <= '0;
            r_sw_rdy  <= 1'b0;
            r_sw_ovr  <= 1'b0;
            r_t_rdy   <= 1'b0;
            r_t_ovr   <= 1'b0;
            r_irqen   <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_we_hex)   r_hex   <= HEXW'(bus.wr_data);
            if (w_we_ledr)  r_ledr  <= NLEDR'(bus.wr_data);
            if (w_we_ledg)  r_ledg  <= NLEDG'(bus.wr_data);
            if (w_we_irqen) r_irqen <= bus.wr_data[IRQ_W-1:0];
            if (w_we_tlim)  r_tlim  <= bus.wr_data;

            if (w_we_tcnt)   r_tcnt <= bus.wr_data;
            else if (w_wrap) r_tcnt <= '0;
            else if (w_tick) r_tcnt <= r_tcnt + DBITS'(1);
            r_psc <= (w_tmr_wr || w_tick) ? '0 : r_psc + PW'(1);

            // Set terms are OR'd after the clear so an event coinciding with a w1c survives.
            r_key_rdy <= (r_key_rdy & ~w_kclr_rdy) | w_key_press;
            r_key_ovr <= (r_key_ovr & ~w_kclr_ovr) | (w_key_press & r_key_rdy);
            r_sw_rdy  <= (r_sw_rdy & ~(w_we_sctrl & bus.wr_data[SCTRL_RDY])) | w_sw_evt;
            r_sw_ovr  <= (r_sw_ovr & ~(w_we_sctrl & bus.wr_data[SCTRL_OVR])) | (w_sw_evt & r_sw_rdy);
            r_t_rdy   <= (r_t_rdy  & ~(w_we_tctrl & bus.wr_data[TCTRL_RDY])) | w_wrap;
            r_t_ovr   <= (r_t_ovr  & ~(w_we_tctrl & bus.wr_data[TCTRL_OVR])) | (w_wrap & r_t_rdy);

            r_irq <= |(r_irqen & w_irq_src);
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            REG_HEX:   w_rd_data = DBITS'(r_hex);
            REG_LEDR:  w_rd_data = DBITS'(r_ledr);
            REG_LEDG:  w_rd_data = DBITS'(r_ledg);
            REG_KDATA: w_rd_data = DBITS'(w_key_q);
            REG_SDATA: w_rd_data = DBITS'(w_sw_q);
            REG_KCTRL: w_rd_data = DBITS'({r_key_ovr, r_key_rdy});
            REG_SCTRL: begin
                w_rd_data[SCTRL_RDY] = r_sw_rdy;
                w_rd_data[SCTRL_OVR] = r_sw_ovr;
            end
            REG_TCNT:  w_rd_data = r_tcnt;
            REG_TLIM:  w_rd_data = r_tlim;
            REG_TCTRL: begin
                w_rd_data[TCTRL_RDY] = r_t_rdy;
                w_rd_data[TCTRL_OVR] = r_t_ovr;
            end
            REG_IRQEN: w_rd_data = DBITS'(r_irqen);
            default:   w_rd_data = '0;
        endcase
    end

    assign bus.rd_data = w_rd_data;
    assign bus.rd_hit  = (w_sel != REG_NONE);
    assign hex         = r_hex;
    assign ledr        = r_ledr;
    assign ledg        = r_ledg;
    assign irq         = r_irq;
endmodule
